// File: rtl/edge_monitor.sv
// Multi-channel edge monitor: synchronise, deglitch, detect edges, latch sticky flags.
// Optional per-channel saturating event counters are built when EDGE_MONITOR_COUNT_EN is defined.
module edge_monitor #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       signal_in,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS-1:0]       level_out,
  output logic [CHANNELS-1:0]       edge_pulse,
  output logic [CHANNELS-1:0]       edge_pending,
  output logic                      irq,
  output logic [CHANNELS*CNT_W-1:0] edge_count
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_out;
  logic [FW-1:0]       filt_cnt [CHANNELS];
  logic [CHANNELS-1:0] accept_p0;
  logic [CHANNELS-1:0] pulse_p0;

  // mode bit 0 enables rising (new level 1), bit 1 enables falling (new level 0)
  function automatic logic edge_enabled(input logic [1:0] m, input logic new_lvl);
    return new_lvl ? m[0] : m[1];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage: synchroniser chain
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= signal_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Stage: filter decision (a change is accepted on its FILTER_CYCLES-th differing cycle)
  always_comb begin
    accept_p0 = '0;
    pulse_p0  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      accept_p0[i] = (sync_out[i] != level_out[i]) && (filt_cnt[i] == FILT_LAST);
      pulse_p0[i]  = accept_p0[i] && edge_enabled(mode[2*i +: 2], sync_out[i]);
    end
  end

  // Stage: registered level, pulse and sticky flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) filt_cnt[i] <= '0;
      level_out    <= '0;
      edge_pulse   <= '0;
      edge_pending <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync_out[i] != level_out[i]) begin
          if (accept_p0[i]) begin
            filt_cnt[i]  <= '0;
            level_out[i] <= sync_out[i];
          end else begin
            filt_cnt[i] <= filt_cnt[i] + 1'b1;
          end
        end else begin
          filt_cnt[i] <= '0;
        end
        // a new edge wins over a simultaneous clear
        edge_pending[i] <= pulse_p0[i] | (edge_pending[i] & ~clear[i]);
      end
      edge_pulse <= pulse_p0;
    end
  end

  assign irq = |edge_pending;

`ifdef EDGE_MONITOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q [CHANNELS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (clear[i]) begin
          cnt_q[i] <= pulse_p0[i] ? CNT_W'(1) : '0;
        end else if (pulse_p0[i]) begin
          cnt_q[i] <= sat_inc(cnt_q[i]);
        end
      end
    end
  end

  always_comb begin
    edge_count = '0;
    for (int i = 0; i < CHANNELS; i++) edge_count[CNT_W*i +: CNT_W] = cnt_q[i];
  end
`else
  assign edge_count = '0;
`endif

endmodule

// File: doc/edge_monitor.md
EDGE_MONITOR -- requirements
Module: edge_monitor

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4: number of independent input channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per channel (>=2).
REQ-003 The block SHALL have parameter FILTER_CYCLES, default 4: consecutive stable cycles required to accept a level change (>=1).
REQ-004 The block SHALL have parameter CNT_W, default 8: per-channel event counter width (1..16).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port signal_in, input, CHANNELS bits: asynchronous raw inputs, bit i = channel i.
REQ-008 The block SHALL have port mode, input, 2*CHANNELS bits: bits [2i+1:2i] select channel i detection as 00 off, 01 rising, 10 falling, 11 both.
REQ-009 The block SHALL have port clear, input, CHANNELS bits: bit i high clears pending flag and counter of channel i.
REQ-010 The block SHALL have port level_out, output, CHANNELS bits: filtered, synchronised level per channel.
REQ-011 The block SHALL have port edge_pulse, output, CHANNELS bits: one-cycle pulse per accepted, enabled edge.
REQ-012 The block SHALL have port edge_pending, output, CHANNELS bits: sticky flag per channel.
REQ-013 The block SHALL have port irq, output, 1 bit: OR of all edge_pending bits.
REQ-014 The block SHALL have port edge_count, output, CHANNELS*CNT_W bits: channel i count at [CNT_W*i +: CNT_W].

Function
REQ-015 Each channel SHALL pass signal_in through a SYNC_STAGES-deep flop chain; sync_out is the last stage.
REQ-016 Each channel SHALL hold a filter counter of width clog2(FILTER_CYCLES+1) that increments while sync_out != level_out and resets to 0 on any cycle where sync_out == level_out.
REQ-017 level_out[i] SHALL toggle, and the filter counter return to 0, on the edge where sync_out has differed from level_out for FILTER_CYCLES consecutive cycles; shorter glitches SHALL be discarded.
REQ-018 edge_pulse[i] SHALL be registered and asserted for exactly one cycle, updating on the same edge as level_out[i], when the transition direction matches mode[i]; mode 00 SHALL never pulse.
REQ-019 Latency from the first clock edge sampling a new input level to level_out/edge_pulse SHALL be SYNC_STAGES+FILTER_CYCLES edges (6 at defaults).
REQ-020 edge_pending[i] SHALL set on the edge edge_pulse[i] asserts and hold until clear[i]; simultaneous set and clear SHALL leave it set.
REQ-021 mode changes SHALL affect only subsequently accepted transitions; existing pending flags and counts SHALL be unaffected.
REQ-022 irq SHALL be the combinational OR of edge_pending.
REQ-023 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each be reported in the same cycle.

Reset
REQ-024 reset SHALL clear synchroniser flops, filter counters, level_out, edge_pulse, edge_pending and edge_count to 0 on the next rising clk edge; irq SHALL then read 0.
REQ-025 Reset asserted mid-filter SHALL discard the in-progress change; an input held high through reset SHALL produce a rising edge SYNC_STAGES+FILTER_CYCLES edges after reset deasserts.

Configuration
REQ-026 With macro EDGE_MONITOR_COUNT_EN defined, each channel SHALL keep a CNT_W-bit counter incremented on each edge_pulse, saturating at 2^CNT_W-1, cleared by clear[i]; clear and increment together SHALL yield 1.
REQ-027 Without EDGE_MONITOR_COUNT_EN, the edge_count port SHALL remain present, be driven constant 0, and no counter registers SHALL be built.

Verification
REQ-028 Defaults, mode=01 on ch0, signal_in[0] 0->1 held -> level_out[0] and edge_pulse[0] high 6 edges later, pulse width 1 cycle, edge_pending[0]=1, irq=1.
REQ-029 Defaults, 3-cycle high glitch on ch1 (mode 11) -> no level_out change, no pulse, pending stays 0.
REQ-030 mode=10 on ch2, input pulse 0->1 (10 cycles) ->0 -> exactly one edge_pulse, on the falling transition only.
REQ-031 clear[3] asserted on the same edge edge_pulse[3] rises -> edge_pending[3]=1 afterwards; count=1 with EDGE_MONITOR_COUNT_EN.
REQ-032 EDGE_MONITOR_COUNT_EN, CNT_W=2, 5 accepted edges on ch0 -> edge_count ch0 reads 1,2,3,3,3; without macro edge_count stays 0.
REQ-033 reset asserted 2 cycles into a filter window with signal_in high -> all outputs 0 next edge; rising pulse 6 edges after reset release.
